// File: rtl/rv_multicycle_core_pkg.sv
// Shared encodings for the multicycle RV32I-subset core: FSM states, ALU ops,
// instruction field constants and the decode table of supported instructions.
package opcodes;

    typedef enum logic [2:0] {
        RESET = 3'b000,
        FETCH = 3'b001,
        EXEC  = 3'b011,
        WB    = 3'b100,
        BREAK = 3'b110,
        ERROR = 3'b111
    } core_state_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    // EBREAK encoding doubles as the halt marker
    localparam logic [31:0] HALT = 32'h0010_0073;

    typedef struct packed {
        logic [31:0] mask;
        logic [31:0] match;
        alu_op_t     op;
        logic        imm;
    } opcode_mask_t;

    localparam logic [31:0] MASK_R = 32'hFE00_707F;
    localparam logic [31:0] MASK_I = 32'h0000_707F;

    function automatic logic [31:0] encode_rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                                 input logic [4:0] rs1, input logic [2:0] f3,
                                                 input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OPC_OP};
    endfunction

    function automatic logic [31:0] encode_itype(input logic [11:0] imm, input logic [4:0] rs1,
                                                 input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, OPC_OP_IMM};
    endfunction

    localparam int NUM_OPS = 19;

    // Immediate shifts carry funct7 in imm[11:5], so they use the R-type mask
    localparam opcode_mask_t OP_TABLE [NUM_OPS] = '{
        '{MASK_R, encode_rtype(F7_BASE, 5'd0, 5'd0, F3_ADD,  5'd0), ALU_ADD,  1'b0},
        '{MASK_R, encode_rtype(F7_ALT,  5'd0, 5'd0, F3_ADD,  5'd0), ALU_SUB,  1'b0},
        '{MASK_R, encode_rtype(F7_BASE, 5'd0, 5'd0, F3_SLL,  5'd0), ALU_SLL,  1'b0},
        '{MASK_R, encode_rtype(F7_BASE, 5'd0, 5'd0, F3_SLT,  5'd0), ALU_SLT,  1'b0},
        '{MASK_R, encode_rtype(F7_BASE, 5'd0, 5'd0, F3_SLTU, 5'd0), ALU_SLTU, 1'b0},
        '{MASK_R, encode_rtype(F7_BASE, 5'd0, 5'd0, F3_XOR,  5'd0), ALU_XOR,  1'b0},
        '{MASK_R, encode_rtype(F7_BASE, 5'd0, 5'd0, F3_SR,   5'd0), ALU_SRL,  1'b0},
        '{MASK_R, encode_rtype(F7_ALT,  5'd0, 5'd0, F3_SR,   5'd0), ALU_SRA,  1'b0},
        '{MASK_R, encode_rtype(F7_BASE, 5'd0, 5'd0, F3_OR,   5'd0), ALU_OR,   1'b0},
        '{MASK_R, encode_rtype(F7_BASE, 5'd0, 5'd0, F3_AND,  5'd0), ALU_AND,  1'b0},
        '{MASK_I, encode_itype(12'h000, 5'd0, F3_ADD,  5'd0), ALU_ADD,  1'b1},
        '{MASK_I, encode_itype(12'h000, 5'd0, F3_SLT,  5'd0), ALU_SLT,  1'b1},
        '{MASK_I, encode_itype(12'h000, 5'd0, F3_SLTU, 5'd0), ALU_SLTU, 1'b1},
        '{MASK_I, encode_itype(12'h000, 5'd0, F3_XOR,  5'd0), ALU_XOR,  1'b1},
        '{MASK_I, encode_itype(12'h000, 5'd0, F3_OR,   5'd0), ALU_OR,   1'b1},
        '{MASK_I, encode_itype(12'h000, 5'd0, F3_AND,  5'd0), ALU_AND,  1'b1},
        '{MASK_R, encode_itype({F7_BASE, 5'd0}, 5'd0, F3_SLL, 5'd0), ALU_SLL, 1'b1},
        '{MASK_R, encode_itype({F7_BASE, 5'd0}, 5'd0, F3_SR,  5'd0), ALU_SRL, 1'b1},
        '{MASK_R, encode_itype({F7_ALT,  5'd0}, 5'd0, F3_SR,  5'd0), ALU_SRA, 1'b1}
    };

endpackage

// File: rtl/rv_multicycle_core_alu.sv
// Combinational integer ALU for the multicycle core; shifts use b[4:0].
module rv_alu
    import opcodes::*;
#(
    parameter int XLEN = 32
) (
    input  alu_op_t         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y
);

    logic [4:0] shamt;
    assign shamt = b[4:0];

    always_comb begin
        y = '0;
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_SLL:  y = a << shamt;
            ALU_SLT:  y = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: y = {{(XLEN-1){1'b0}}, a < b};
            ALU_XOR:  y = a ^ b;
            ALU_SRL:  y = a >> shamt;
            ALU_SRA:  y = $signed(a) >>> shamt;
            ALU_OR:   y = a | b;
            ALU_AND:  y = a & b;
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/rv_multicycle_core.sv
// Multicycle RV32I-subset core: FETCH -> EXEC -> WB per instruction, halting
// in BREAK on the halt marker or ERROR on any unsupported encoding.
module rv_multicycle_core
    import opcodes::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter int              IMEM_AW  = 16,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               imem_valid,
    output logic               halted,
    output logic               error,
    output logic [XLEN-1:0]    pc,
    output logic [31:0]        retired
);

    core_state_t state, state_next;
    logic [31:0]     ir;
    logic [XLEN-1:0] result;

    // Only cleared at power-up so the register contents survive rst
    logic [XLEN-1:0] reg_file [NREGS] = '{default: '0};

    logic [4:0]      rs1, rs2, rd;
    logic [XLEN-1:0] rs1_val, rs2_val, imm, alu_b, alu_y;
    logic            dec_legal, dec_imm;
    alu_op_t         dec_op;

    assign rs1 = ir[19:15];
    assign rs2 = ir[24:20];
    assign rd  = ir[11:7];

    assign rs1_val = (rs1 == 5'd0) ? '0 : reg_file[rs1];
    assign rs2_val = (rs2 == 5'd0) ? '0 : reg_file[rs2];
    assign imm     = {{(XLEN-12){ir[31]}}, ir[31:20]};
    assign alu_b   = dec_imm ? imm : rs2_val;

    always_comb begin
        dec_legal = 1'b0;
        dec_op    = ALU_ADD;
        dec_imm   = 1'b0;
        for (int i = 0; i < NUM_OPS; i++) begin
            if ((ir & OP_TABLE[i].mask) == OP_TABLE[i].match) begin
                dec_legal = 1'b1;
                dec_op    = OP_TABLE[i].op;
                dec_imm   = OP_TABLE[i].imm;
            end
        end
    end

    rv_alu #(.XLEN(XLEN)) u_alu (
        .op (dec_op),
        .a  (rs1_val),
        .b  (alu_b),
        .y  (alu_y)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= RESET;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            RESET: state_next = FETCH;
            FETCH: if (imem_valid) state_next = EXEC;
            EXEC: begin
                if (ir == HALT)     state_next = BREAK;
                else if (!dec_legal) state_next = ERROR;
                else                state_next = WB;
            end
            WB:      state_next = FETCH;
            default: state_next = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state == FETCH && imem_valid) ir <= imem_rdata;
        if (state == EXEC) result <= alu_y;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= RESET_PC;
            retired <= '0;
        end else if (state == WB) begin
            pc      <= pc + XLEN'(4);
            retired <= retired + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state == WB && rd != 5'd0) reg_file[rd] <= result;
    end

    assign imem_req  = (state == FETCH);
    assign imem_addr = pc[IMEM_AW+1:2];
    assign halted    = (state == BREAK);
    assign error     = (state == ERROR);

endmodule

// File: doc/rv_multicycle_core.md
Name: rv_multicycle_core

Overview:
- Multicycle RV32I-subset integer core; the first real core that replaces the `dut` stub used by the quick-test bench.
- Fetches from an external instruction memory over a req/valid handshake.
- Executes R-type and I-type ALU instructions on an internal register file.
- Stops in BREAK on opcodes::HALT, or in ERROR on any unsupported encoding.
- `reg_file` and `state` are hierarchically accessible so the bench can preload operands and poll for completion.

Parameters:
- XLEN, 32, datapath and register width
- NREGS, 32, register count; x0 is hardwired to zero
- IMEM_AW, 16, instruction memory word-address width
- RESET_PC, 0, byte address loaded into pc during reset

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request, held until accepted
- imem_addr  out  IMEM_AW  word address of fetch, equal to pc[IMEM_AW+1:2]
- imem_rdata  in  32  instruction word; valid when imem_valid=1
- imem_valid  in  1  one-cycle strobe completing the outstanding fetch
- halted  out  1  high while state==BREAK
- error  out  1  high while state==ERROR
- pc  out  XLEN  current program counter, byte address
- retired  out  32  count of instructions written back since reset

Behaviour:
- State encoding (3 bits, packaged): RESET=000, FETCH=001, EXEC=011, WB=100, BREAK=110, ERROR=111.
  - BREAK must equal 3'b110.
  - `state` is a named internal register.
- rst=1 at a clock edge:
  - state<=RESET, pc<=RESET_PC, retired<=0.
  - imem_req, halted and error are 0 the next cycle.
  - reg_file is NOT cleared by rst; it is zeroed only at time 0, so the bench can preload before resetting.
- RESET -> FETCH on the first edge with rst=0.
- FETCH:
  - imem_req=1, imem_addr=pc[IMEM_AW+1:2].
  - Waits any number of cycles.
  - On an edge with imem_valid=1: latch imem_rdata into ir, go to EXEC.
  - imem_valid while not in FETCH is ignored.
- EXEC:
  - Decode ir, read rs1/rs2 (x0 reads 0), compute result into a result register.
  - ir==HALT -> BREAK; no writeback, pc unchanged.
  - Unsupported opcode/funct3/funct7 -> ERROR; pc unchanged.
  - Otherwise -> WB.
- WB:
  - If rd!=0, write result to reg_file[rd].
  - pc<=pc+4 (wraps modulo 2^XLEN), retired<=retired+1, then -> FETCH.
  - Minimum latency per instruction is 3 cycles with zero-wait memory.
- Supported instructions:
  - R-type: ADD SUB SLL SLT SLTU XOR SRL SRA OR AND.
  - I-type: ADDI SLTI SLTIU XORI ORI ANDI SLLI SRLI SRAI.
  - Immediates are sign-extended 12-bit.
  - Shift amount is the low 5 bits.
  - Arithmetic is two's complement, truncated to XLEN, with no overflow flag.
- BREAK and ERROR are terminal; only rst leaves them.
- rst asserted in any state (mid-fetch, EXEC, WB) aborts the instruction:
  - No register write occurs on that edge.
  - imem_req drops the next cycle.
- A write and a read of the same register never overlap, since the core is multicycle with no forwarding.

Decomposition:
- Package opcodes holds:
  - core_state_t enum with the encodings above
  - opcode_mask_t entries for all supported instructions
  - the HALT constant
  - funct3/funct7 constants
  - alu_op_t enum
  - encode_rtype/encode_itype functions
- One sub-module, rv_alu: combinational; alu_op_t, two XLEN operands -> XLEN result.
- The FSM, decode and register file stay in rv_multicycle_core.

Test Plan:
- Arithmetic pass:
  - Stimulus: x2=10, x3=20, mem[0]=ADD x1,x2,x3, mem[1]=HALT, zero-wait memory, pulse rst.
  - Required response: state reaches BREAK, x1=30, retired=1, pc=4, halted=1.
- Signed subtract and right shifts:
  - Stimulus: x8=-10, x7=-20, SUB x6,x8,x7; then SRAI x5,x6,1; then SRLI x4,x8,28.
  - Required response: x6=10, x5=5, x4=15, retired=3.
- x0 and signed compares:
  - Stimulus: ADDI x0,x0,5; then SLT x1,x2,x3 with x2=-1, x3=1; then SLTU x4,x2,x3.
  - Required response: x0 reads 0, x1=1, x4=0.
- Fetch wait states:
  - Stimulus: imem_valid delayed 4 cycles per request.
  - Required response: imem_req and imem_addr stay stable until valid, results are identical to the zero-wait run, and the cycle count grows by 4 per instruction.
- Illegal instruction:
  - Stimulus: mem[0]=32'hFFFF_FFFF.
  - Required response: state=ERROR, error=1, pc=0, retired=0, no register changed.
- Reset mid-operation:
  - Stimulus: assert rst during EXEC of ADD x1,x2,x3 with x1 preloaded to 7.
  - Required response: x1 stays 7, state=RESET, pc=RESET_PC; after release the program reruns and x1=30.
